// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and state encodings for the instruction-fetch stage
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam int          IF_TO_ID_W       = 64;

    // Field offsets inside the IF->ID bus {inst, pc}
    localparam int PC_LSB   = 0;
    localparam int PC_MSB   = 31;
    localparam int INST_LSB = 32;
    localparam int INST_MSB = 63;

    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_REQ  = 1'b1
    } pf_state_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_WAIT  = 2'd1,
        SLOT_READY = 2'd2
    } slot_state_t;

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: one outstanding SRAM read, stall buffer, redirect squash
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_allowin,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    output logic                  if_to_id_valid,
    output logic [IF_TO_ID_W-1:0] if_to_id_wire,
    output logic                  inst_sram_req,
    output logic [31:0]           inst_sram_addr,
    input  logic                  inst_sram_addr_ok,
    input  logic                  inst_sram_data_ok,
    input  logic [31:0]           inst_sram_rdata
);

    pf_state_t   pf_state, pf_next;
    slot_state_t slot_state, slot_next;

    logic        fetch_en;
    logic        discard;
    logic        pf_cancel;
    logic        pf_from_br;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;
    logic [31:0] seq_pc;
    logic [31:0] pf_addr;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;

    logic        slot_data;
    logic        leaving;
    logic        start;
    logic        accept;
    logic        cancelled;
    logic        accept_live;
    logic        from_br;
    logic [31:0] issue_addr;

    assign slot_data      = (slot_state == SLOT_WAIT) & inst_sram_data_ok & ~discard;
    assign if_to_id_valid = slot_data | (slot_state == SLOT_READY);
    assign leaving        = if_to_id_valid & id_allowin;

    // fetch_en keeps req low in the first cycle after reset is sampled
    assign start = fetch_en & ~discard & ~br_taken & ((slot_state == SLOT_EMPTY) | leaving);

    assign inst_sram_req  = (pf_state == PF_REQ) | ((pf_state == PF_IDLE) & start);
    assign issue_addr     = (pf_state == PF_REQ) ? pf_addr : (br_buf_valid ? br_buf_target : seq_pc);
    assign from_br        = (pf_state == PF_REQ) ? pf_from_br : br_buf_valid;
    assign inst_sram_addr = issue_addr;

    assign accept      = inst_sram_req & inst_sram_addr_ok;
    assign cancelled   = pf_cancel | br_taken;
    assign accept_live = accept & ~cancelled;

    assign if_to_id_wire[INST_MSB:INST_LSB] = (slot_state == SLOT_READY) ? inst_buf : inst_sram_rdata;
    assign if_to_id_wire[PC_MSB:PC_LSB]     = fs_pc;

    always_comb begin
        pf_next = pf_state;
        if (pf_state == PF_IDLE) begin
            if (start & ~inst_sram_addr_ok) pf_next = PF_REQ;
        end else begin
            if (inst_sram_addr_ok) pf_next = PF_IDLE;
        end

        slot_next = slot_state;
        if (br_taken)                      slot_next = SLOT_EMPTY;
        else if (accept_live)              slot_next = SLOT_WAIT;
        else if (leaving)                  slot_next = SLOT_EMPTY;
        else if (slot_data & ~id_allowin)  slot_next = SLOT_READY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_state      <= PF_IDLE;
            slot_state    <= SLOT_EMPTY;
            fetch_en      <= 1'b0;
            discard       <= 1'b0;
            pf_cancel     <= 1'b0;
            pf_from_br    <= 1'b0;
            br_buf_valid  <= 1'b0;
            br_buf_target <= 32'd0;
            seq_pc        <= RESET_PC;
            pf_addr       <= 32'd0;
            fs_pc         <= 32'd0;
            inst_buf      <= 32'd0;
        end else begin
            fetch_en   <= 1'b1;
            pf_state   <= pf_next;
            slot_state <= slot_next;

            if ((pf_state == PF_IDLE) & start) begin
                pf_addr    <= issue_addr;
                pf_from_br <= br_buf_valid;
            end

            if (accept) seq_pc <= issue_addr + 32'd4;

            if ((pf_state == PF_REQ) & br_taken & ~inst_sram_addr_ok) pf_cancel <= 1'b1;
            else if (accept)                                          pf_cancel <= 1'b0;

            if (br_taken) begin
                br_buf_valid  <= 1'b1;
                br_buf_target <= br_target;
            end else if (accept_live & from_br) begin
                br_buf_valid  <= 1'b0;
            end

            // A squashed request still returns data once; discard swallows exactly that beat
            if ((br_taken & (slot_state == SLOT_WAIT) & ~inst_sram_data_ok) | (accept & cancelled))
                discard <= 1'b1;
            else if (discard & inst_sram_data_ok)
                discard <= 1'b0;

            if (accept_live) fs_pc <= issue_addr;

            if (slot_data & ~id_allowin) inst_buf <= inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && discard) begin
            assert (slot_state == SLOT_EMPTY);
            assert (!(accept && cancelled && !inst_sram_data_ok));
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage with an SRAM responder model
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_allowin = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_wire;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int aok_mode = 1;
    int dly_lo = 0;
    int dly_hi = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .id_allowin        (id_allowin),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_wire     (if_to_id_wire),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (addr_ok),
        .inst_sram_data_ok (data_ok),
        .inst_sram_rdata   (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    // In-order SRAM: accepted reads return 1+delay cycles later
    always @(negedge clk) begin
        case (aok_mode)
            0:       addr_ok = 1'b0;
            1:       addr_ok = 1'b1;
            default: addr_ok = ($urandom_range(0, 99) < 60);
        endcase
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            data_ok = 1'b1;
            rdata   = mem_word(q_addr[0]);
        end else begin
            data_ok = 1'b0;
            rdata   = $urandom;
        end
        #3;
        if (reset) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (data_ok) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (inst_sram_req && addr_ok) begin
                q_addr.push_back(inst_sram_addr);
                q_due.push_back(cyc + 1 + int'($urandom_range(dly_lo, dly_hi)));
            end
        end
    end

    task automatic step(input logic ai, input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        id_allowin = ai;
        br_taken   = bt;
        br_target  = tgt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        aok_mode = 1; dly_lo = 0; dly_hi = 0;
        @(negedge clk);
        reset = 1'b1; id_allowin = 1'b1; br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_sram_req !== 1'b0) begin
                failures++; $display("FAIL reset_req cyc%0d got=%b exp=0", i, inst_sram_req);
            end
            checks++;
            if (if_to_id_valid !== 1'b0) begin
                failures++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, if_to_id_valid);
            end
            checks++;
            if (inst_sram_addr !== RST_PC) begin
                failures++; $display("FAIL reset_addr cyc%0d got=%h exp=%h", i, inst_sram_addr, RST_PC);
            end
        end
        reset = 1'b0;
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
            failures++; $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=%h", inst_sram_req, inst_sram_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        aok_mode = 1; dly_lo = 0; dly_hi = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC + 32'(4 * k)) begin
                failures++; $display("FAIL seq_req k=%0d got req=%b addr=%h exp addr=%h", k, inst_sram_req, inst_sram_addr, RST_PC + 32'(4 * k));
            end
            if (k > 0) begin
                pc = RST_PC + 32'(4 * (k - 1));
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire !== {mem_word(pc), pc}) begin
                    failures++; $display("FAIL seq_bus k=%0d got valid=%b wire=%h exp wire=%h", k, if_to_id_valid, if_to_id_wire, {mem_word(pc), pc});
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc;
        logic ai;
        aok_mode = 1; dly_lo = 0; dly_hi = 0;
        do_reset();
        pc = RST_PC + 32'd4;
        for (int k = 0; k < 7; k++) begin
            ai = !(k >= 2 && k <= 4);
            step(ai, 1'b0, 32'd0);
            if (k >= 2 && k <= 5) begin
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire !== {mem_word(pc), pc}) begin
                    failures++; $display("FAIL stall_hold k=%0d got valid=%b wire=%h exp wire=%h", k, if_to_id_valid, if_to_id_wire, {mem_word(pc), pc});
                end
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if (inst_sram_req !== 1'b0) begin
                    failures++; $display("FAIL stall_noreq k=%0d got req=%b exp=0", k, inst_sram_req);
                end
            end
            if (k == 5) begin
                checks++;
                if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC + 32'd8) begin
                    failures++; $display("FAIL stall_release_req got req=%b addr=%h exp addr=%h", inst_sram_req, inst_sram_addr, RST_PC + 32'd8);
                end
            end
            if (k == 6) begin
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire[31:0] !== RST_PC + 32'd8) begin
                    failures++; $display("FAIL stall_next_pc got valid=%b pc=%h exp pc=%h", if_to_id_valid, if_to_id_wire[31:0], RST_PC + 32'd8);
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        localparam logic [31:0] TGT = 32'h1c000100;
        aok_mode = 1; dly_lo = 3; dly_hi = 3;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(1'b1, k == 1, (k == 1) ? TGT : 32'd0);
            if (k == 1) begin
                dly_lo = 0; dly_hi = 0;
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (if_to_id_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
                    failures++; $display("FAIL redir_wait_quiet k=%0d got valid=%b req=%b exp 0 0", k, if_to_id_valid, inst_sram_req);
                end
            end
            if (k == 5) begin
                checks++;
                if (inst_sram_req !== 1'b1 || inst_sram_addr !== TGT) begin
                    failures++; $display("FAIL redir_wait_req got req=%b addr=%h exp addr=%h", inst_sram_req, inst_sram_addr, TGT);
                end
            end
            if (k == 6) begin
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire !== {mem_word(TGT), TGT}) begin
                    failures++; $display("FAIL redir_wait_bus got valid=%b wire=%h exp wire=%h", if_to_id_valid, if_to_id_wire, {mem_word(TGT), TGT});
                end
            end
        end
    endtask

    task automatic test_redirect_pending();
        localparam logic [31:0] TGT = 32'h1c000200;
        aok_mode = 0; dly_lo = 0; dly_hi = 0;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            aok_mode = (k <= 2) ? 0 : 1;
            step(1'b1, k == 1, (k == 1) ? TGT : 32'd0);
            if (k >= 1 && k <= 3) begin
                checks++;
                if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
                    failures++; $display("FAIL redir_pend_hold k=%0d got req=%b addr=%h exp addr=%h", k, inst_sram_req, inst_sram_addr, RST_PC);
                end
            end
            if (k == 4) begin
                checks++;
                if (if_to_id_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
                    failures++; $display("FAIL redir_pend_drop got valid=%b req=%b exp 0 0", if_to_id_valid, inst_sram_req);
                end
            end
            if (k == 5) begin
                checks++;
                if (inst_sram_req !== 1'b1 || inst_sram_addr !== TGT) begin
                    failures++; $display("FAIL redir_pend_req got req=%b addr=%h exp addr=%h", inst_sram_req, inst_sram_addr, TGT);
                end
            end
            if (k == 6) begin
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire[31:0] !== TGT || inst_sram_addr !== TGT + 32'd4) begin
                    failures++; $display("FAIL redir_pend_after got valid=%b pc=%h addr=%h exp pc=%h addr=%h", if_to_id_valid, if_to_id_wire[31:0], inst_sram_addr, TGT, TGT + 32'd4);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        aok_mode = 1; dly_lo = 2; dly_hi = 2;
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (inst_sram_req !== 1'b0 || if_to_id_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_quiet got req=%b valid=%b exp 0 0", inst_sram_req, if_to_id_valid);
        end
        reset = 1'b0;
        dly_lo = 0; dly_hi = 0;
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC || if_to_id_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_restart got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", inst_sram_req, inst_sram_addr, if_to_id_valid, RST_PC);
        end
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (if_to_id_valid !== 1'b1 || if_to_id_wire !== {mem_word(RST_PC), RST_PC}) begin
            failures++; $display("FAIL rst_mid_bus got valid=%b wire=%h exp wire=%h", if_to_id_valid, if_to_id_wire, {mem_word(RST_PC), RST_PC});
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt, prev_addr;
        logic [63:0] prev_wire;
        logic        prev_hold, prev_pend, ai, bt;
        int          delivered;
        aok_mode = 2; dly_lo = 0; dly_hi = 4;
        do_reset();
        exp_pc = RST_PC; prev_hold = 1'b0; prev_pend = 1'b0; delivered = 0;
        prev_addr = 32'd0; prev_wire = 64'd0;
        for (int c = 0; c < 3000; c++) begin
            ai  = ($urandom_range(0, 99) < 70);
            bt  = ($urandom_range(0, 99) < 4);
            tgt = 32'h1c000000 | ($urandom & 32'h0000fffc);
            step(ai, bt, tgt);
            if (prev_hold) begin
                checks++;
                if (if_to_id_valid !== 1'b1 || if_to_id_wire !== prev_wire) begin
                    failures++; $display("FAIL rnd_bus_stable c=%0d got valid=%b wire=%h exp wire=%h", c, if_to_id_valid, if_to_id_wire, prev_wire);
                end
            end
            if (prev_pend) begin
                checks++;
                if (inst_sram_req !== 1'b1 || inst_sram_addr !== prev_addr) begin
                    failures++; $display("FAIL rnd_req_sticky c=%0d got req=%b addr=%h exp addr=%h", c, inst_sram_req, inst_sram_addr, prev_addr);
                end
            end
            checks++;
            if (q_addr.size() > 1) begin
                failures++; $display("FAIL rnd_outstanding c=%0d got=%0d exp<=1", c, q_addr.size());
            end
            if (if_to_id_valid === 1'b1 && ai) begin
                checks++;
                if (if_to_id_wire !== {mem_word(exp_pc), exp_pc}) begin
                    failures++; $display("FAIL rnd_stream c=%0d got wire=%h exp wire=%h", c, if_to_id_wire, {mem_word(exp_pc), exp_pc});
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (bt) exp_pc = tgt;
            prev_hold = (if_to_id_valid === 1'b1) && !ai && !bt;
            prev_wire = if_to_id_wire;
            prev_pend = (inst_sram_req === 1'b1) && !addr_ok;
            prev_addr = inst_sram_addr;
        end
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (delivered < 200) begin
            failures++; $display("FAIL rnd_progress got=%0d exp>=200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_pending();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
